regfile_scoreboarded: RTL and testbench
=======================================

// Module: regfile_scoreboarded
// PURPOSE
//  Parametrised integer register file with an integrated busy-bit scoreboard for the RV32IM pipeline.
//  Two combinational read ports and one synchronous write-back port. A per-register pending bit is set
//  when the decode stage issues an instruction to a destination, and cleared when that result is written back.
//  Sits between decode (reads, issue) and write-back (write, clear). Decode uses the busy flags to drive hazard stall logic.
// PARAMETERS
//  XLEN      32  data width of each register
//  NREGS     32  number of architectural registers; must be a power of two, >= 2
//  AW        $clog2(NREGS)  register address width (derived, do not override)
//  ZERO_REG  1   1: register 0 reads 0, ignores writes and is never pending; 0: register 0 is an ordinary register
// PORTS
//  clk          in   1     rising-edge clock
//  reset        in   1     asynchronous, active-high reset
//  addr1        in   AW    read port 1 address
//  addr2        in   AW    read port 2 address
//  data1        out  XLEN  read port 1 data
//  data2        out  XLEN  read port 2 data
//  busy1        out  1     register at addr1 has a write pending
//  busy2        out  1     register at addr2 has a write pending
//  write_enable in   1     write-back strobe
//  write_reg_addr in AW    write-back destination
//  reg_write_data in XLEN  write-back data
//  issue_en     in   1     mark issue_addr as pending at the next clk edge
//  issue_addr   in   AW    destination register of the issuing instruction
//  any_pending  out  1     OR of all pending bits; used for pipeline drain and fence
// BEHAVIOUR
//  Reset: asserting reset immediately (asynchronously) clears all registers and all pending bits to 0.
//   While reset is held, data1/2 = 0, busy1/2 = 0 and any_pending = 0. Writes and issues are ignored.
//  Reads are combinational from the array and add 0 cycles of latency. Out-of-range addresses cannot occur (NREGS = 2**AW).
//  Write: at posedge clk, if write_enable is 1, reg_write_data is stored at write_reg_addr. Visible to reads from the next cycle (bypass off).
//  Scoreboard, per register r, evaluated at posedge clk:
//   Set if issue_en is 1 and issue_addr == r.
//   Clear if write_enable is 1 and write_reg_addr == r.
//   If set and clear happen together for the same r, set wins: a new producer is now in flight.
//   Otherwise the bit holds its value.
//  Issuing to an already-pending register is legal; the bit stays set.
//   One write-back clears the bit, so in-order completion is required of the pipeline.
//  A write to a register that is not pending is legal. The data is stored and the bit stays 0.
//  ZERO_REG=1: data1/2 = 0 when the address is 0. A write to 0 is discarded. An issue to 0 does not set a pending bit. busy1/2 = 0 for address 0.
//  any_pending reflects the registered pending bits only and is not bypassed.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   If write_enable is 1 and write_reg_addr == addrN (and addrN is not the zero register), dataN = reg_write_data
//    in that same cycle, and busyN is forced to 0 in that cycle.
//   Exception: if issue_en is also 1 with issue_addr == addrN, busyN stays 1.
//  REGFILE_BYPASS_EN undefined:
//   No forwarding. dataN and busyN come only from stored state, so the write is visible one cycle later.
// STRUCTURE
//  Shared package rv32_pkg: XLEN constant, typedef reg_addr_t (logic [AW-1:0]), typedef xword_t (logic [XLEN-1:0]).
//  Sub-module regfile_scoreboard: holds the NREGS pending bits and the set/clear priority logic, and drives busy1/2 and any_pending.
//   It takes the read addresses and the issue and write strobes as inputs.
//  The top level holds the data array, the read muxes, the zero-register masking and the optional bypass muxes.
// TESTING
//  Reset: load x5=32'hDEAD_BEEF and mark it pending, then pulse reset mid-cycle
//   -> data1(addr1=5)=0, busy1=0 and any_pending=0 before the next edge.
//  Zero register: write x0=32'h1234_5678 and issue to x0
//   -> data1(addr1=0)=0, busy1=0 and any_pending stays 0.
//  Scoreboard: issue x7 in cycle 0, so busy2(addr2=7)=1 in cycles 1-3. Write x7=32'hA5A5_0001 in cycle 3
//   -> busy2=0 and data2=32'hA5A5_0001 in cycle 4.
//  Same-cycle set and clear: x9 pending. In one cycle, issue x9 and write x9=32'h0000_0042
//   -> next cycle busy1(addr1=9)=1 and data1=32'h42.
//  Dual read with a write to another register: x3=1 and x4=2, read both while writing x3=3
//   -> data2(addr2=4)=2 is unchanged. data1=3 in the write cycle when REGFILE_BYPASS_EN is defined, otherwise 1 in that cycle and 3 in the next.
//  any_pending: issue x1, x2 and x3 in consecutive cycles, then write them back in order
//   -> any_pending=1 from the first issue until the cycle after the x3 write, then 0.

Source files
------------

// File: rtl/regfile_scoreboarded_pkg.sv
// Shared RV32 types and constants for the register file and its scoreboard.
package rv32_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xword_t;

endpackage

// File: rtl/regfile_scoreboarded_if.sv
// Decode/write-back bus of the register file: reads, busy flags, write-back and issue.
interface regfile_scoreboarded_if #(
    parameter int XLEN = rv32_pkg::XLEN,
    parameter int AW   = rv32_pkg::AW
) ();
    import rv32_pkg::*;

    logic [AW-1:0]   addr1;
    logic [AW-1:0]   addr2;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            busy1;
    logic            busy2;
    logic            write_enable;
    logic [AW-1:0]   write_reg_addr;
    logic [XLEN-1:0] reg_write_data;
    logic            issue_en;
    logic [AW-1:0]   issue_addr;
    logic            any_pending;

    modport master (
        output addr1, addr2, write_enable, write_reg_addr, reg_write_data, issue_en, issue_addr,
        input  data1, data2, busy1, busy2, any_pending
    );

    modport slave (
        input  addr1, addr2, write_enable, write_reg_addr, reg_write_data, issue_en, issue_addr,
        output data1, data2, busy1, busy2, any_pending
    );

endinterface

// File: rtl/regfile_scoreboarded_scoreboard.sv
// Per-register pending bits with set-over-clear priority; drives busy1/2 and any_pending.
// Same-cycle write-back forwarding of the busy flags is enabled by REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_addr,
    input  logic          write_enable,
    input  logic [AW-1:0] write_reg_addr,
    output logic          busy1,
    output logic          busy2,
    output logic          any_pending
);
    import rv32_pkg::*;

    logic [NREGS-1:0] pending_r;
    logic [NREGS-1:0] pending_nxt_s;

    // Next pending state: an issue to r wins over a write-back to r in the same cycle.
    always_comb begin
        pending_nxt_s = pending_r;
        for (int r = 0; r < NREGS; r++) begin
            if (issue_en && (issue_addr == AW'(r)) && !(ZERO_REG && (r == 0))) begin
                pending_nxt_s[r] = 1'b1;
            end else if (write_enable && (write_reg_addr == AW'(r))) begin
                pending_nxt_s[r] = 1'b0;
            end else begin
                pending_nxt_s[r] = pending_r[r];
            end
        end
    end

    // Pending-bit state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Busy flags for the two read ports.
    always_comb begin
        busy1 = pending_r[addr1];
        busy2 = pending_r[addr2];
`ifdef REGFILE_BYPASS_EN
        // A completing write-back frees the register this cycle unless it is reissued now.
        if (!reset && write_enable && (write_reg_addr == addr1) && !(ZERO_REG && (addr1 == '0))) begin
            busy1 = issue_en && (issue_addr == addr1);
        end else begin
            busy1 = pending_r[addr1];
        end
        if (!reset && write_enable && (write_reg_addr == addr2) && !(ZERO_REG && (addr2 == '0))) begin
            busy2 = issue_en && (issue_addr == addr2);
        end else begin
            busy2 = pending_r[addr2];
        end
`endif
    end

    assign any_pending = |pending_r;

endmodule

// File: rtl/regfile_scoreboarded.sv
// RV32 integer register file with busy-bit scoreboard: two combinational reads, one write-back.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data and busy release to the read ports.
module regfile_scoreboarded #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input logic                   clk,
    input logic                   reset,
    regfile_scoreboarded_if.slave bus
);
    import rv32_pkg::*;

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs_r [NREGS];
    logic            wr_ok_s;

    assign wr_ok_s = bus.write_enable && !(ZERO_REG && (bus.write_reg_addr == '0));

    // Data array: cleared on reset, written on an accepted write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= '0;
            end
        end else if (wr_ok_s) begin
            regs_r[bus.write_reg_addr] <= bus.reg_write_data;
        end
    end

    // Read muxes with zero-register masking and optional write-back forwarding.
    always_comb begin
        bus.data1 = regs_r[bus.addr1];
        bus.data2 = regs_r[bus.addr2];
`ifdef REGFILE_BYPASS_EN
        if (!reset && wr_ok_s && (bus.write_reg_addr == bus.addr1)) begin
            bus.data1 = bus.reg_write_data;
        end else begin
            bus.data1 = regs_r[bus.addr1];
        end
        if (!reset && wr_ok_s && (bus.write_reg_addr == bus.addr2)) begin
            bus.data2 = bus.reg_write_data;
        end else begin
            bus.data2 = regs_r[bus.addr2];
        end
`endif
        if (ZERO_REG && (bus.addr1 == '0)) begin
            bus.data1 = '0;
        end else begin
            bus.data1 = bus.data1;
        end
        if (ZERO_REG && (bus.addr2 == '0)) begin
            bus.data2 = '0;
        end else begin
            bus.data2 = bus.data2;
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk            (clk),
        .reset          (reset),
        .addr1          (bus.addr1),
        .addr2          (bus.addr2),
        .issue_en       (bus.issue_en),
        .issue_addr     (bus.issue_addr),
        .write_enable   (bus.write_enable),
        .write_reg_addr (bus.write_reg_addr),
        .busy1          (bus.busy1),
        .busy2          (bus.busy2),
        .any_pending    (bus.any_pending)
    );

endmodule

// File: tb/tb_regfile_scoreboarded.sv
// Directed scoreboard bench for regfile_scoreboarded (default and REGFILE_BYPASS_EN builds).
module tb_regfile_scoreboarded;
    import rv32_pkg::*;

    localparam int P_DATA1 = 0;
    localparam int P_DATA2 = 1;
    localparam int P_BUSY1 = 2;
    localparam int P_BUSY2 = 3;
    localparam int P_ANY   = 4;

    typedef struct {
        string       name;
        int          port;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    regfile_scoreboarded_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regfile_scoreboarded #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input string n, input int p, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.port = p;
        e.val  = v;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.write_enable = 1'b0;
        bus.issue_en     = 1'b0;
    endtask

    task automatic do_write(input reg_addr_t a, input xword_t d);
        bus.write_enable   = 1'b1;
        bus.write_reg_addr = a;
        bus.reg_write_data = d;
    endtask

    task automatic do_issue(input reg_addr_t a);
        bus.issue_en   = 1'b1;
        bus.issue_addr = a;
    endtask

    // Monitor: compare every expectation queued for the current cycle at the falling edge.
    exp_t        mon_e;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            case (mon_e.port)
                P_DATA1: mon_act = bus.data1;
                P_DATA2: mon_act = bus.data2;
                P_BUSY1: mon_act = {31'd0, bus.busy1};
                P_BUSY2: mon_act = {31'd0, bus.busy2};
                P_ANY:   mon_act = {31'd0, bus.any_pending};
                default: mon_act = 32'hxxxx_xxxx;
            endcase
            checks++;
            if (mon_act !== mon_e.val) begin
                errors++;
                $display("FAIL %s (cycle %0d): got %h, expected %h", mon_e.name, cyc, mon_act, mon_e.val);
            end
        end
    end

    initial begin
        bus.addr1 = '0;
        bus.addr2 = '0;
        bus.write_enable = 1'b0;
        bus.write_reg_addr = '0;
        bus.reg_write_data = '0;
        bus.issue_en = 1'b0;
        bus.issue_addr = '0;

        // Power-on reset
        step();
        bus.addr1 = 5'd5;
        push_exp("por_data1", P_DATA1, 32'h0);
        push_exp("por_any", P_ANY, 32'h0);
        step();
        reset = 1'b0;

        // Reset clears a loaded, pending register
        step();
        do_write(5'd5, 32'hDEAD_BEEF);
        do_issue(5'd5);
        step();
        push_exp("rst_pre_data1", P_DATA1, 32'hDEAD_BEEF);
        push_exp("rst_pre_busy1", P_BUSY1, 32'h1);
        push_exp("rst_pre_any", P_ANY, 32'h1);
        step();
        #1;
        reset = 1'b1;
        push_exp("rst_data1", P_DATA1, 32'h0);
        push_exp("rst_busy1", P_BUSY1, 32'h0);
        push_exp("rst_any", P_ANY, 32'h0);
        #5;
        reset = 1'b0;
        step();
        push_exp("rst_after_data1", P_DATA1, 32'h0);
        push_exp("rst_after_busy1", P_BUSY1, 32'h0);

        // Zero register
        step();
        bus.addr1 = 5'd0;
        do_write(5'd0, 32'h1234_5678);
        do_issue(5'd0);
        push_exp("zero_wr_data1", P_DATA1, 32'h0);
        push_exp("zero_wr_busy1", P_BUSY1, 32'h0);
        step();
        push_exp("zero_data1", P_DATA1, 32'h0);
        push_exp("zero_busy1", P_BUSY1, 32'h0);
        push_exp("zero_any", P_ANY, 32'h0);

        // Scoreboard lifetime of x7
        step();
        bus.addr2 = 5'd7;
        do_issue(5'd7);
        push_exp("sb_c0_busy2", P_BUSY2, 32'h0);
        step();
        push_exp("sb_c1_busy2", P_BUSY2, 32'h1);
        step();
        push_exp("sb_c2_busy2", P_BUSY2, 32'h1);
        step();
        do_write(5'd7, 32'hA5A5_0001);
`ifdef REGFILE_BYPASS_EN
        push_exp("sb_c3_busy2", P_BUSY2, 32'h0);
        push_exp("sb_c3_data2", P_DATA2, 32'hA5A5_0001);
`else
        push_exp("sb_c3_busy2", P_BUSY2, 32'h1);
        push_exp("sb_c3_data2", P_DATA2, 32'h0);
`endif
        step();
        push_exp("sb_c4_busy2", P_BUSY2, 32'h0);
        push_exp("sb_c4_data2", P_DATA2, 32'hA5A5_0001);
        push_exp("sb_c4_any", P_ANY, 32'h0);

        // Same-cycle set and clear on x9: set wins
        step();
        bus.addr1 = 5'd9;
        do_issue(5'd9);
        step();
        do_issue(5'd9);
        do_write(5'd9, 32'h0000_0042);
        push_exp("setclr_now_busy1", P_BUSY1, 32'h1);
        step();
        push_exp("setclr_busy1", P_BUSY1, 32'h1);
        push_exp("setclr_data1", P_DATA1, 32'h0000_0042);
        push_exp("setclr_any", P_ANY, 32'h1);
        step();
        do_write(5'd9, 32'h0000_0043);
        step();
        push_exp("setclr_done_busy1", P_BUSY1, 32'h0);
        push_exp("setclr_done_any", P_ANY, 32'h0);

        // Dual read while writing another value to x3
        step();
        do_write(5'd3, 32'h1);
        step();
        do_write(5'd4, 32'h2);
        step();
        bus.addr1 = 5'd3;
        bus.addr2 = 5'd4;
        do_write(5'd3, 32'h3);
        push_exp("dual_wr_data2", P_DATA2, 32'h2);
`ifdef REGFILE_BYPASS_EN
        push_exp("dual_wr_data1", P_DATA1, 32'h3);
`else
        push_exp("dual_wr_data1", P_DATA1, 32'h1);
`endif
        step();
        push_exp("dual_next_data1", P_DATA1, 32'h3);
        push_exp("dual_next_data2", P_DATA2, 32'h2);

        // any_pending across three in-flight producers
        step();
        bus.addr1 = 5'd1;
        do_issue(5'd1);
        push_exp("anyp_i1", P_ANY, 32'h0);
        step();
        do_issue(5'd2);
        push_exp("anyp_i2", P_ANY, 32'h1);
        push_exp("anyp_i2_busy1", P_BUSY1, 32'h1);
        step();
        do_issue(5'd3);
        push_exp("anyp_i3", P_ANY, 32'h1);
        step();
        do_write(5'd1, 32'h11);
        push_exp("anyp_w1", P_ANY, 32'h1);
        step();
        do_write(5'd2, 32'h22);
        push_exp("anyp_w2", P_ANY, 32'h1);
        push_exp("anyp_w2_busy1", P_BUSY1, 32'h0);
        step();
        do_write(5'd3, 32'h33);
        push_exp("anyp_w3", P_ANY, 32'h1);
        step();
        push_exp("anyp_done", P_ANY, 32'h0);
        push_exp("anyp_data1", P_DATA1, 32'h11);

        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL unchecked_expectations: got %0d left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
